// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, default slot
// map and the default-slave state encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // HADDR[31:24] regions of the four peripheral slots
    localparam logic [7:0] DEF_S0_BASE = 8'h00;  // ROM
    localparam logic [7:0] DEF_S1_BASE = 8'h20;  // RAM
    localparam logic [7:0] DEF_S2_BASE = 8'h50;  // LED register
    localparam logic [7:0] DEF_S3_BASE = 8'h51;  // UART

    // One-hot data-phase select layout {DEF, S3, S2, S1, S0}
    localparam int NUM_SLOTS = 4;
    localparam int SEL_DEF   = 4;
    localparam logic [NUM_SLOTS:0] DSEL_RESET = 5'b1_0000;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } def_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with the two-cycle
// AHB ERROR response; idle/busy transfers get a zero-wait OKAY.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hready,     // muxed bus ready (address phase accepted when 1)
    input  logic sel_def,    // address phase decodes to no slot
    input  logic active,     // HTRANS[1]: NONSEQ or SEQ
    output logic hreadyout,
    output logic hresp
);

    def_state_t state, state_nxt;

    wire start_err = hready & sel_def & active;

    // State register; reset abandons any error in progress
    always_ff @(posedge clk) begin
        if (rst) state <= DS_IDLE;
        else     state <= state_nxt;
    end

    // Next state and response outputs
    always_comb begin
        state_nxt = state;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (start_err) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                // Next address phase is accepted in this cycle
                hresp     = HRESP_ERROR;
                state_nxt = start_err ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: address decode to four slots,
// registered data-phase select, response mux and default slave.
module ahb_lite_interconnect
    import ahb_pkg::*;
#(
    parameter logic [7:0] S0_BASE = DEF_S0_BASE,
    parameter logic [7:0] S1_BASE = DEF_S1_BASE,
    parameter logic [7:0] S2_BASE = DEF_S2_BASE,
    parameter logic [7:0] S3_BASE = DEF_S3_BASE
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HSEL_S0,
    output logic        HSEL_S1,
    output logic        HSEL_S2,
    output logic        HSEL_S3,
    input  logic [31:0] HRDATA_S0,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,
    input  logic [31:0] HRDATA_S3,
    input  logic        HREADYOUT_S0,
    input  logic        HREADYOUT_S1,
    input  logic        HREADYOUT_S2,
    input  logic        HREADYOUT_S3,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    logic [NUM_SLOTS:0] dec;
    logic [NUM_SLOTS:0] dsel;
    logic               def_hreadyout;
    logic               def_hresp;

    // Only the region byte and the active bit of HTRANS are decoded
    logic unused_bits;
    assign unused_bits = ^{HADDR[23:0], HTRANS[0]};

    // Priority address decode; S0 wins if regions overlap
    always_comb begin
        dec = '0;
        if      (HADDR[31:24] == S0_BASE) dec[0]       = 1'b1;
        else if (HADDR[31:24] == S1_BASE) dec[1]       = 1'b1;
        else if (HADDR[31:24] == S2_BASE) dec[2]       = 1'b1;
        else if (HADDR[31:24] == S3_BASE) dec[3]       = 1'b1;
        else                              dec[SEL_DEF] = 1'b1;
    end

    assign HSEL_S0 = dec[0];
    assign HSEL_S1 = dec[1];
    assign HSEL_S2 = dec[2];
    assign HSEL_S3 = dec[3];

    // Data-phase select advances only when the bus accepts an address phase
    always_ff @(posedge HCLK) begin
        if (HRESET)      dsel <= DSEL_RESET;
        else if (HREADY) dsel <= dec;
    end

    // Response mux driven by the data-phase owner
    always_comb begin
        HRDATA = 32'h0;
        HREADY = def_hreadyout;
        HRESP  = def_hresp;
        if (dsel[0]) begin
            HRDATA = HRDATA_S0; HREADY = HREADYOUT_S0; HRESP = HRESP_OKAY;
        end else if (dsel[1]) begin
            HRDATA = HRDATA_S1; HREADY = HREADYOUT_S1; HRESP = HRESP_OKAY;
        end else if (dsel[2]) begin
            HRDATA = HRDATA_S2; HREADY = HREADYOUT_S2; HRESP = HRESP_OKAY;
        end else if (dsel[3]) begin
            HRDATA = HRDATA_S3; HREADY = HREADYOUT_S3; HRESP = HRESP_OKAY;
        end
    end

    ahb_default_slave u_def (
        .clk       (HCLK),
        .rst       (HRESET),
        .hready    (HREADY),
        .sel_def   (dec[SEL_DEF]),
        .active    (HTRANS[1]),
        .hreadyout (def_hreadyout),
        .hresp     (def_hresp)
    );

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 time unit later.
module tb_ahb_lite_interconnect;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3;
    logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
    logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_interconnect dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSEL_S0(HSEL_S0), .HSEL_S1(HSEL_S1), .HSEL_S2(HSEL_S2), .HSEL_S3(HSEL_S3),
        .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1),
        .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
        .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1),
        .HREADYOUT_S2(HREADYOUT_S2), .HREADYOUT_S3(HREADYOUT_S3),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    wire [3:0] hsel = {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0};

    // advance to the next cycle, leaving room to drive inputs
    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        HADDR  = 32'h5000_0000;
        HTRANS = 2'b00;
        next_cycle();
        next_cycle();
        #1;
        tests++; if (HREADY !== 1'b1) begin fails++; $display("FAIL reset_hready got %b want 1", HREADY); end
        tests++; if (HRESP !== 1'b0) begin fails++; $display("FAIL reset_hresp got %b want 0", HRESP); end
        tests++; if (HRDATA !== 32'h0) begin fails++; $display("FAIL reset_hrdata got %h want 0", HRDATA); end
        tests++; if (hsel !== 4'b0100) begin fails++; $display("FAIL reset_hsel got %b want 0100", hsel); end
        HRESET = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] addrs [6] = '{32'h0000_1234, 32'h20FF_FFFC, 32'h50AB_CDEF,
                                   32'h5100_0008, 32'h5200_0000, 32'h2100_0000};
        logic [3:0]  exp   [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        HTRANS = 2'b00;
        for (int i = 0; i < 6; i++) begin
            HADDR = addrs[i];
            #1;
            tests++;
            if (hsel !== exp[i]) begin
                fails++;
                $display("FAIL decode_%0d addr %h got %b want %b", i, addrs[i], hsel, exp[i]);
            end
        end
        next_cycle();
    endtask

    task automatic test_led();
        // address phase: write to LED
        HADDR = 32'h5000_0000; HTRANS = 2'b10;
        next_cycle();
        // write data phase + read address phase
        HRDATA_S2 = 32'h0000_00A5;
        #1;
        tests++; if (HREADY !== 1'b1) begin fails++; $display("FAIL led_write_ready got %b want 1", HREADY); end
        next_cycle();
        HTRANS = 2'b00;
        #1;
        tests++; if (HRDATA !== 32'h0000_00A5) begin fails++; $display("FAIL led_read_data got %h want 000000a5", HRDATA); end
        tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin fails++; $display("FAIL led_read_resp got rdy=%b resp=%b want rdy=1 resp=0", HREADY, HRESP); end
        next_cycle();
    endtask

    task automatic test_wait_state();
        int low_cnt = 0;
        HADDR = 32'h2000_0010; HTRANS = 2'b10;
        next_cycle();
        // data phase: next address phase held by master
        HADDR = 32'h5000_0000; HTRANS = 2'b00;
        HREADYOUT_S1 = 1'b0; HRDATA_S1 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (HREADY === 1'b0) low_cnt++;
            tests++; if (HRDATA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wait_track_%0d got %h want deadbeef", i, HRDATA); end
            next_cycle();
        end
        HREADYOUT_S1 = 1'b1; HRDATA_S1 = 32'h1234_5678;
        #1;
        tests++; if (low_cnt != 3) begin fails++; $display("FAIL wait_low_cycles got %0d want 3", low_cnt); end
        tests++; if (HREADY !== 1'b1) begin fails++; $display("FAIL wait_release got %b want 1", HREADY); end
        tests++; if (HRDATA !== 32'h1234_5678) begin fails++; $display("FAIL wait_data got %h want 12345678", HRDATA); end
        next_cycle();
        // dsel moved on to S2 (IDLE address accepted above)
        HRDATA_S1 = 32'h0;
        #1;
        tests++; if (HRDATA !== HRDATA_S2) begin fails++; $display("FAIL wait_next_owner got %h want %h", HRDATA, HRDATA_S2); end
    endtask

    task automatic test_unmapped();
        HADDR = 32'hF000_0000; HTRANS = 2'b10;
        next_cycle();
        HADDR = 32'h0; HTRANS = 2'b00;
        #1;
        tests++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin fails++; $display("FAIL unmapped_c1 got rdy=%b resp=%b want rdy=0 resp=1", HREADY, HRESP); end
        tests++; if (HRDATA !== 32'h0) begin fails++; $display("FAIL unmapped_data got %h want 0", HRDATA); end
        next_cycle();
        HADDR = 32'hF000_0000; HTRANS = 2'b00;  // IDLE to unmapped region
        #1;
        tests++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin fails++; $display("FAIL unmapped_c2 got rdy=%b resp=%b want rdy=1 resp=1", HREADY, HRESP); end
        next_cycle();
        #1;
        tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin fails++; $display("FAIL unmapped_idle got rdy=%b resp=%b want rdy=1 resp=0", HREADY, HRESP); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [6] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b10}; // {HREADY,HRESP}
        HADDR = 32'hF000_0000; HTRANS = 2'b10;
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin HADDR = 32'hF000_0004; HTRANS = 2'b10; end
            if (i == 3) begin HADDR = 32'h0000_0000; HTRANS = 2'b00; end
            #1;
            tests++;
            if ({HREADY, HRESP} !== exp[i]) begin
                fails++;
                $display("FAIL b2b_c%0d got rdy=%b resp=%b want %b", i, HREADY, HRESP, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_error();
        HADDR = 32'hF000_0000; HTRANS = 2'b10;
        next_cycle();
        HADDR = 32'h0; HTRANS = 2'b10; HRESET = 1'b1;
        #1;
        tests++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin fails++; $display("FAIL rst_mid_err1 got rdy=%b resp=%b want rdy=0 resp=1", HREADY, HRESP); end
        next_cycle();
        HRESET = 1'b0; HRDATA_S0 = 32'hCAFE_F00D;
        #1;
        tests++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin fails++; $display("FAIL rst_mid_after got rdy=%b resp=%b want rdy=1 resp=0", HREADY, HRESP); end
        tests++; if (hsel !== 4'b0001) begin fails++; $display("FAIL rst_mid_hsel got %b want 0001", hsel); end
        next_cycle();
        HTRANS = 2'b00;
        #1;
        tests++; if (HRDATA !== 32'hCAFE_F00D || HRESP !== 1'b0 || HREADY !== 1'b1) begin
            fails++; $display("FAIL rst_mid_s0 got data=%h rdy=%b resp=%b want cafef00d/1/0", HRDATA, HREADY, HRESP);
        end
        next_cycle();
    endtask

    initial begin
        HRESET = 1'b1; HADDR = 32'h0; HTRANS = 2'b00;
        HRDATA_S0 = 32'h0; HRDATA_S1 = 32'h0; HRDATA_S2 = 32'h0; HRDATA_S3 = 32'h0;
        HREADYOUT_S0 = 1'b1; HREADYOUT_S1 = 1'b1; HREADYOUT_S2 = 1'b1; HREADYOUT_S3 = 1'b1;
        #1;
        test_reset();
        test_decode();
        test_led();
        test_wait_state();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
